bram_arbiter: RTL and testbench

BRAM_ARBITER -- requirements
Module: bram_arbiter

---
 rtl/bram_arb_pkg.sv | 15 +
 rtl/bram_arb_rr.sv | 22 ++
 rtl/bram_arbiter.sv | 158 +++++++++++++++
 tb/tb_bram_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types for the two-port BRAM arbiter: lock FSM states and port index.
package bram_arb_pkg;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    typedef logic port_idx_t;

    localparam port_idx_t PORT0 = 1'b0;
    localparam port_idx_t PORT1 = 1'b1;

endpackage

// File: rtl/bram_arb_rr.sv
// Two-way round-robin pick: on a conflict the port that did not win last time is granted.
module bram_arb_rr
    import bram_arb_pkg::*;
(
    input  logic       valid_0,
    input  logic       valid_1,
    input  port_idx_t  last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid_0 && valid_1) begin
            grant = (last_grant == PORT1) ? 2'b01 : 2'b10;
        end else if (valid_0) begin
            grant = 2'b01;
        end else if (valid_1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous-read BRAM.
// Ownership locking and its timeout are built only when BRAM_ARB_LOCK_EN is defined.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int ADDR_WIDTH   = 14,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,

    input  logic                  REQ_VALID_0,
    input  logic                  REQ_WE_0,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR_0,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA_0,
    input  logic                  REQ_LOCK_0,
    output logic                  REQ_READY_0,
    output logic                  RSP_VALID_0,
    output logic [DATA_WIDTH-1:0] RSP_DATA_0,

    input  logic                  REQ_VALID_1,
    input  logic                  REQ_WE_1,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR_1,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA_1,
    input  logic                  REQ_LOCK_1,
    output logic                  REQ_READY_1,
    output logic                  RSP_VALID_1,
    output logic [DATA_WIDTH-1:0] RSP_DATA_1,

    output logic                  MEM_WE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_DIN,
    input  logic [DATA_WIDTH-1:0] MEM_DOUT,
    output logic                  LOCK_ERR
);

    arb_state_t state;
    port_idx_t  last_grant;
    port_idx_t  gidx;
    logic [1:0] elig;
    logic [1:0] grant;
    logic       xfer;
    logic       gwe;
    logic [1:0] rd_vld_p1;

    // A held lock hides the other port from the round-robin pick.
    always_comb begin
        elig[0] = REQ_VALID_0 && (state != ST_LOCK1);
        elig[1] = REQ_VALID_1 && (state != ST_LOCK0);
    end

    bram_arb_rr u_rr (
        .valid_0    (elig[0]),
        .valid_1    (elig[1]),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign REQ_READY_0 = grant[0] & RST_N;
    assign REQ_READY_1 = grant[1] & RST_N;
    assign xfer        = REQ_READY_0 | REQ_READY_1;
    assign gidx        = port_idx_t'(grant[1]);
    assign gwe         = (gidx == PORT1) ? REQ_WE_1 : REQ_WE_0;

    // Stage p0: request cycle drives the memory port; idle cycles present port 0.
    assign MEM_WE   = xfer & gwe;
    assign MEM_ADDR = RST_N ? ((gidx == PORT1) ? REQ_ADDR_1  : REQ_ADDR_0)  : '0;
    assign MEM_DIN  = RST_N ? ((gidx == PORT1) ? REQ_WDATA_1 : REQ_WDATA_0) : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_grant <= PORT1;
            rd_vld_p1  <= 2'b00;
        end else begin
            if (xfer) begin
                last_grant <= gidx;
            end
            rd_vld_p1[0] <= xfer & ~gwe & (gidx == PORT0);
            rd_vld_p1[1] <= xfer & ~gwe & (gidx == PORT1);
        end
    end

    // Stage p1: BRAM read data returns and is steered to the port that issued the read.
    assign RSP_VALID_0 = rd_vld_p1[0];
    assign RSP_VALID_1 = rd_vld_p1[1];
    assign RSP_DATA_0  = rd_vld_p1[0] ? MEM_DOUT : '0;
    assign RSP_DATA_1  = rd_vld_p1[1] ? MEM_DOUT : '0;

`ifdef BRAM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    arb_state_t       state_nxt;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] idle_cnt_nxt;
    logic             glock;
    logic             timeout;
    logic             lock_err_r;

    assign glock = (gidx == PORT1) ? REQ_LOCK_1 : REQ_LOCK_0;

    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = idle_cnt;
        timeout      = 1'b0;
        case (state)
            ST_ARB: begin
                idle_cnt_nxt = '0;
                if (xfer && glock) begin
                    state_nxt = (gidx == PORT1) ? ST_LOCK1 : ST_LOCK0;
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                // Only the owner can transfer here, so any xfer is the owner's.
                if (xfer) begin
                    idle_cnt_nxt = '0;
                    if (!glock) begin
                        state_nxt = ST_ARB;
                    end
                end else if (idle_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_nxt    = ST_ARB;
                    idle_cnt_nxt = '0;
                    timeout      = 1'b1;
                end else begin
                    idle_cnt_nxt = idle_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt    = ST_ARB;
                idle_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_ARB;
            idle_cnt   <= '0;
            lock_err_r <= 1'b0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_cnt_nxt;
            if (timeout) begin
                lock_err_r <= 1'b1;
            end
        end
    end

    assign LOCK_ERR = lock_err_r;
`else
    logic lock_unused;

    assign state       = ST_ARB;
    assign LOCK_ERR    = 1'b0;
    assign lock_unused = REQ_LOCK_0 | REQ_LOCK_1;
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural synchronous-read BRAM attached.
module tb_bram_arbiter;

    localparam int DW = 4;
    localparam int AW = 14;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          REQ_VALID_0, REQ_WE_0, REQ_LOCK_0, REQ_READY_0, RSP_VALID_0;
    logic [AW-1:0] REQ_ADDR_0;
    logic [DW-1:0] REQ_WDATA_0, RSP_DATA_0;
    logic          REQ_VALID_1, REQ_WE_1, REQ_LOCK_1, REQ_READY_1, RSP_VALID_1;
    logic [AW-1:0] REQ_ADDR_1;
    logic [DW-1:0] REQ_WDATA_1, RSP_DATA_1;
    logic          MEM_WE, LOCK_ERR;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_DIN;
    logic [DW-1:0] MEM_DOUT = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_TIMEOUT(16)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID_0(REQ_VALID_0), .REQ_WE_0(REQ_WE_0), .REQ_ADDR_0(REQ_ADDR_0),
        .REQ_WDATA_0(REQ_WDATA_0), .REQ_LOCK_0(REQ_LOCK_0), .REQ_READY_0(REQ_READY_0),
        .RSP_VALID_0(RSP_VALID_0), .RSP_DATA_0(RSP_DATA_0),
        .REQ_VALID_1(REQ_VALID_1), .REQ_WE_1(REQ_WE_1), .REQ_ADDR_1(REQ_ADDR_1),
        .REQ_WDATA_1(REQ_WDATA_1), .REQ_LOCK_1(REQ_LOCK_1), .REQ_READY_1(REQ_READY_1),
        .RSP_VALID_1(RSP_VALID_1), .RSP_DATA_1(RSP_DATA_1),
        .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT),
        .LOCK_ERR(LOCK_ERR)
    );

    // Read-before-write BRAM: a same-cycle write does not affect the data read out.
    always @(posedge CLK) begin
        if (MEM_WE) mem[MEM_ADDR] <= MEM_DIN;
        MEM_DOUT <= mem[MEM_ADDR];
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        REQ_VALID_0 = 0; REQ_WE_0 = 0; REQ_ADDR_0 = '0; REQ_WDATA_0 = '0; REQ_LOCK_0 = 0;
        REQ_VALID_1 = 0; REQ_WE_1 = 0; REQ_ADDR_1 = '0; REQ_WDATA_1 = '0; REQ_LOCK_1 = 0;
    endtask

    task automatic drive0(input logic v, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic lk);
        REQ_VALID_0 = v; REQ_WE_0 = we; REQ_ADDR_0 = a; REQ_WDATA_0 = d; REQ_LOCK_0 = lk;
    endtask

    task automatic drive1(input logic v, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic lk);
        REQ_VALID_1 = v; REQ_WE_1 = we; REQ_ADDR_1 = a; REQ_WDATA_1 = d; REQ_LOCK_1 = lk;
    endtask

    task automatic test_reset();
        drive0(1, 1, 14'h0123, 4'h7, 1);
        drive1(1, 0, 14'h0234, 4'h3, 1);
        repeat (2) @(negedge CLK);
        checks++; if ({REQ_READY_0, REQ_READY_1, MEM_WE, RSP_VALID_0, RSP_VALID_1, LOCK_ERR} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000000",
                {REQ_READY_0, REQ_READY_1, MEM_WE, RSP_VALID_0, RSP_VALID_1, LOCK_ERR}); end
        checks++; if ({MEM_ADDR, MEM_DIN, RSP_DATA_0, RSP_DATA_1} !== '0) begin
            errors++; $display("FAIL reset_data: addr=%h din=%h r0=%h r1=%h want all 0",
                MEM_ADDR, MEM_DIN, RSP_DATA_0, RSP_DATA_1); end
        idle_inputs();
        RST_N = 1'b1;
    endtask

    task automatic test_conflict();
        step(); drive0(1, 0, 14'h0005, 0, 0); drive1(1, 0, 14'h0006, 0, 0);
        @(negedge CLK);
        checks++; if ({REQ_READY_0, REQ_READY_1} !== 2'b10) begin errors++;
            $display("FAIL conflict_c1_ready: got r0=%b r1=%b want r0=1 r1=0", REQ_READY_0, REQ_READY_1); end
        checks++; if (MEM_ADDR !== 14'h0005) begin errors++;
            $display("FAIL conflict_c1_addr: got %h want 0005", MEM_ADDR); end
        step(); REQ_VALID_0 = 0;
        @(negedge CLK);
        checks++; if ({REQ_READY_0, REQ_READY_1} !== 2'b01) begin errors++;
            $display("FAIL conflict_c2_ready: got r0=%b r1=%b want r0=0 r1=1", REQ_READY_0, REQ_READY_1); end
        checks++; if (MEM_ADDR !== 14'h0006) begin errors++;
            $display("FAIL conflict_c2_addr: got %h want 0006", MEM_ADDR); end
        checks++; if ({RSP_VALID_0, RSP_VALID_1, RSP_DATA_0} !== {2'b10, 4'h8}) begin errors++;
            $display("FAIL conflict_rsp0: got v0=%b v1=%b d0=%h want v0=1 v1=0 d0=8",
                RSP_VALID_0, RSP_VALID_1, RSP_DATA_0); end
        step(); idle_inputs();
        @(negedge CLK);
        checks++; if ({RSP_VALID_0, RSP_VALID_1, RSP_DATA_0, RSP_DATA_1} !== {2'b01, 4'h0, 4'h9}) begin errors++;
            $display("FAIL conflict_rsp1: got v0=%b v1=%b d0=%h d1=%h want v0=0 v1=1 d0=0 d1=9",
                RSP_VALID_0, RSP_VALID_1, RSP_DATA_0, RSP_DATA_1); end
    endtask

    task automatic test_write_read();
        step(); drive0(1, 1, 14'h0010, 4'hA, 0);
        @(negedge CLK);
        checks++; if ({REQ_READY_0, MEM_WE, MEM_ADDR, MEM_DIN} !== {2'b11, 14'h0010, 4'hA}) begin errors++;
            $display("FAIL wr_mem: got rdy=%b we=%b addr=%h din=%h want 1 1 0010 a",
                REQ_READY_0, MEM_WE, MEM_ADDR, MEM_DIN); end
        step(); idle_inputs(); drive1(1, 0, 14'h0010, 0, 0);
        @(negedge CLK);
        checks++; if ({REQ_READY_1, MEM_WE, RSP_VALID_0} !== 3'b100) begin errors++;
            $display("FAIL rd_after_wr: got rdy1=%b we=%b v0=%b want 1 0 0", REQ_READY_1, MEM_WE, RSP_VALID_0); end
        step(); idle_inputs();
        @(negedge CLK);
        checks++; if ({RSP_VALID_1, RSP_DATA_1} !== {1'b1, 4'hA}) begin errors++;
            $display("FAIL rd_after_wr_rsp: got v1=%b d1=%h want 1 a", RSP_VALID_1, RSP_DATA_1); end
    endtask

    task automatic test_back_to_back();
        logic exp0;
        step(); drive0(1, 0, 14'h0021, 0, 0); drive1(1, 0, 14'h0022, 0, 0);
        for (int k = 0; k < 8; k++) begin
            if (k != 0) step();
            @(negedge CLK);
            exp0 = ((k % 2) == 0);
            checks++; if ({REQ_READY_0, REQ_READY_1} !== {exp0, ~exp0}) begin errors++;
                $display("FAIL b2b_grant[%0d]: got r0=%b r1=%b want r0=%b r1=%b",
                    k, REQ_READY_0, REQ_READY_1, exp0, ~exp0); end
            if (k != 0) begin
                checks++; if ({RSP_VALID_0, RSP_VALID_1, RSP_DATA_0, RSP_DATA_1} !==
                              (exp0 ? {2'b01, 4'h0, 4'h5} : {2'b10, 4'h4, 4'h0})) begin errors++;
                    $display("FAIL b2b_rsp[%0d]: got v0=%b v1=%b d0=%h d1=%h",
                        k, RSP_VALID_0, RSP_VALID_1, RSP_DATA_0, RSP_DATA_1); end
            end
        end
        step(); idle_inputs();
        @(negedge CLK);
        checks++; if ({RSP_VALID_1, RSP_DATA_1} !== {1'b1, 4'h5}) begin errors++;
            $display("FAIL b2b_last_rsp: got v1=%b d1=%h want 1 5", RSP_VALID_1, RSP_DATA_1); end
    endtask

    task automatic test_read_then_write();
        step(); drive0(1, 0, 14'h0030, 0, 0);
        @(negedge CLK);
        checks++; if (REQ_READY_0 !== 1'b1) begin errors++;
            $display("FAIL rmw_rd_ready: got %b want 1", REQ_READY_0); end
        step(); drive0(1, 1, 14'h0030, 4'hF, 0);
        @(negedge CLK);
        checks++; if ({MEM_WE, RSP_VALID_0, RSP_DATA_0} !== {2'b11, 4'h3}) begin errors++;
            $display("FAIL rmw_prewrite: got we=%b v0=%b d0=%h want 1 1 3", MEM_WE, RSP_VALID_0, RSP_DATA_0); end
        step(); drive0(1, 0, 14'h0030, 0, 0);
        @(negedge CLK);
        checks++; if ({REQ_READY_0, RSP_VALID_0, RSP_DATA_0} !== {2'b10, 4'h0}) begin errors++;
            $display("FAIL rmw_no_wr_rsp: got rdy=%b v0=%b d0=%h want 1 0 0", REQ_READY_0, RSP_VALID_0, RSP_DATA_0); end
        step(); idle_inputs();
        @(negedge CLK);
        checks++; if ({RSP_VALID_0, RSP_DATA_0} !== {1'b1, 4'hF}) begin errors++;
            $display("FAIL rmw_postwrite: got v0=%b d0=%h want 1 f", RSP_VALID_0, RSP_DATA_0); end
    endtask

`ifdef BRAM_ARB_LOCK_EN
    task automatic test_lock_release();
        step(); drive0(1, 0, 14'h0050, 0, 0); drive1(1, 0, 14'h0051, 0, 1);
        @(negedge CLK);
        checks++; if ({REQ_READY_0, REQ_READY_1} !== 2'b01) begin errors++;
            $display("FAIL lock_take: got r0=%b r1=%b want 0 1", REQ_READY_0, REQ_READY_1); end
        drive1(0, 0, 14'h0051, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge CLK);
            checks++; if (REQ_READY_0 !== 1'b0) begin errors++;
                $display("FAIL lock_hold[%0d]: got r0=%b want 0", i, REQ_READY_0); end
        end
        step(); drive1(1, 1, 14'h0051, 4'h7, 0);
        @(negedge CLK);
        checks++; if ({REQ_READY_0, REQ_READY_1, MEM_WE} !== 3'b011) begin errors++;
            $display("FAIL lock_unlock_wr: got r0=%b r1=%b we=%b want 0 1 1", REQ_READY_0, REQ_READY_1, MEM_WE); end
        step(); drive1(0, 0, '0, 0, 0);
        @(negedge CLK);
        checks++; if (REQ_READY_0 !== 1'b1) begin errors++;
            $display("FAIL lock_released: got r0=%b want 1", REQ_READY_0); end
    endtask

    task automatic test_lock_timeout();
        step(); idle_inputs(); drive0(1, 0, 14'h0060, 0, 1);
        @(negedge CLK);
        checks++; if (REQ_READY_0 !== 1'b1) begin errors++;
            $display("FAIL to_take: got r0=%b want 1", REQ_READY_0); end
        step(); idle_inputs(); drive1(1, 0, 14'h0061, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            if (i != 1) step();
            @(negedge CLK);
            checks++; if ({REQ_READY_1, LOCK_ERR} !== 2'b00) begin errors++;
                $display("FAIL to_idle[%0d]: got r1=%b err=%b want 0 0", i, REQ_READY_1, LOCK_ERR); end
        end
        step();
        @(negedge CLK);
        checks++; if ({REQ_READY_1, LOCK_ERR} !== 2'b11) begin errors++;
            $display("FAIL to_expire: got r1=%b err=%b want 1 1", REQ_READY_1, LOCK_ERR); end
        step(); idle_inputs();
        @(negedge CLK);
        checks++; if (LOCK_ERR !== 1'b1) begin errors++;
            $display("FAIL to_sticky: got err=%b want 1", LOCK_ERR); end
    endtask
`else
    task automatic test_lock_ignored();
        step(); idle_inputs(); drive1(1, 0, 14'h0040, 0, 1);
        @(negedge CLK);
        checks++; if (REQ_READY_1 !== 1'b1) begin errors++;
            $display("FAIL nolock_r1: got %b want 1", REQ_READY_1); end
        step(); idle_inputs(); drive0(1, 0, 14'h0041, 0, 0);
        @(negedge CLK);
        checks++; if ({REQ_READY_0, LOCK_ERR} !== 2'b10) begin errors++;
            $display("FAIL nolock_r0: got r0=%b err=%b want 1 0", REQ_READY_0, LOCK_ERR); end
    endtask
`endif

    task automatic test_reset_inflight();
        step(); idle_inputs(); drive0(1, 0, 14'h0005, 0, 0);
        @(negedge CLK);
        checks++; if (REQ_READY_0 !== 1'b1) begin errors++;
            $display("FAIL rst_rd_ready: got %b want 1", REQ_READY_0); end
        step(); idle_inputs(); RST_N = 1'b0;
        #1;
        checks++; if ({RSP_VALID_0, RSP_DATA_0} !== 5'b0) begin errors++;
            $display("FAIL rst_async_clear: got v0=%b d0=%h want 0 0", RSP_VALID_0, RSP_DATA_0); end
        drive0(1, 1, 14'h0077, 4'h5, 0);
        @(negedge CLK);
        checks++; if ({REQ_READY_0, REQ_READY_1, MEM_WE, RSP_VALID_0, RSP_VALID_1, LOCK_ERR,
                       MEM_ADDR, MEM_DIN, RSP_DATA_0, RSP_DATA_1} !== '0) begin errors++;
            $display("FAIL rst_outputs: rdy=%b%b we=%b v=%b%b err=%b addr=%h din=%h want all 0",
                REQ_READY_0, REQ_READY_1, MEM_WE, RSP_VALID_0, RSP_VALID_1, LOCK_ERR, MEM_ADDR, MEM_DIN); end
        idle_inputs();
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge CLK);
            checks++; if ({RSP_VALID_0, RSP_VALID_1} !== 2'b00) begin errors++;
                $display("FAIL rst_no_rsp[%0d]: got v0=%b v1=%b want 0 0", i, RSP_VALID_0, RSP_VALID_1); end
        end
        step(); drive0(1, 0, 14'h0001, 0, 0); drive1(1, 0, 14'h0002, 0, 0);
        @(negedge CLK);
        checks++; if ({REQ_READY_0, REQ_READY_1} !== 2'b10) begin errors++;
            $display("FAIL rst_last_grant: got r0=%b r1=%b want 1 0", REQ_READY_0, REQ_READY_1); end
        step(); idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i[3:0] + 4'd3);
        idle_inputs();
        RST_N = 1'b0;
        test_reset();
        test_conflict();
        test_write_read();
        test_back_to_back();
        test_read_then_write();
`ifdef BRAM_ARB_LOCK_EN
        test_lock_release();
        test_lock_timeout();
`else
        test_lock_ignored();
`endif
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
